// File: rtl/ptranspose_pkg.sv
// ptranspose_pkg: helpers shared by the scatter and gather transposes.
// Bank index/address containers, page and job sizing, lane rotation.
package ptranspose_pkg;

   // Wide containers; callers cast down to their own bank/address widths.
   typedef logic [7:0]  bank_idx_t;
   typedef logic [31:0] bank_addr_t;

   localparam int STAT_W = 32;

   function automatic int beats_per_job(
      input int ii,
      input int jj,
      input int simd
   );
      return (ii * jj) / simd;
   endfunction

   function automatic int page_off(
      input int ii,
      input int jj,
      input int simd
   );
      return beats_per_job(ii, jj, simd);
   endfunction

   function automatic int bank_depth(
      input int ii,
      input int jj,
      input int simd
   );
      return 2 * beats_per_job(ii, jj, simd);
   endfunction

   // Lane k of a row beat lives in bank (row + k) % simd.
   function automatic bank_idx_t rot_lanes(
      input int lane,
      input int rot,
      input int simd
   );
      return bank_idx_t'((lane + rot) % simd);
   endfunction

   // Inverse of the scatter: lane of a column beat that feeds bank b.
   // Rows in a column beat start on a multiple of simd, so only the
   // column index shifts the mapping.
   function automatic bank_idx_t lane_of(
      input int bank,
      input int col,
      input int simd
   );
      return bank_idx_t'((bank - (col % simd) + simd) % simd);
   endfunction

   // Element (row, col) of page pg sits at pg*P + row*(J/simd) + col/simd.
   function automatic bank_addr_t bank_addr(
      input logic pg,
      input int   row,
      input int   col,
      input int   ii,
      input int   jj,
      input int   simd
   );
      int base;
      base = pg ? page_off(ii, jj, simd) : 0;
      return bank_addr_t'(base + row * (jj / simd) + col / simd);
   endfunction

endpackage

// File: rtl/ptranspose_scatter_bank.sv
// ptranspose_scatter_bank: one simple-dual-port element bank.
// Ports: clk; i_we/i_waddr/i_wdata write side; i_re/i_raddr read side;
// o_rdata is registered and holds its value while i_re is low.
module ptranspose_scatter_bank
   import ptranspose_pkg::*;
#(
   parameter int BITS  = 8,
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input  logic            clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [BITS-1:0] i_wdata,
   input  logic            i_re,
   input  logic [AW-1:0]   i_raddr,
   output logic [BITS-1:0] o_rdata
);

   logic [BITS-1:0] r_mem [DEPTH];
   logic [BITS-1:0] r_q;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (i_re) begin
         r_q <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_q;

endmodule

// File: rtl/ptranspose_scatter.sv
// ptranspose_scatter: streaming (J,I) column-major to (I,J) row-major
// transpose. Writes scatter element (i,j) into bank (i+j)%SIMD so both a
// column beat and a row beat touch every bank once; two pages let one job
// fill while the previous one drains.
// Ports: clk, rst (async, active high)
//   ivld/irdy/idat : input beats, lane k = (i0+k, j), j outer, i0 inner
//   ovld/ordy/odat : output beats, lane k = (i, j0+k), i outer, j0 inner
// Build option PTRANSPOSE_SCATTER_STATS_EN adds jobs_in, jobs_out and
// stall_cnt (32-bit wrapping counters).
module ptranspose_scatter
   import ptranspose_pkg::*;
#(
   parameter int BITS = 8,
   parameter int I    = 8,
   parameter int J    = 8,
   parameter int SIMD = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic                 irdy,
   input  logic                 ivld,
   input  logic [SIMD*BITS-1:0] idat,
   input  logic                 ordy,
   output logic                 ovld,
   output logic [SIMD*BITS-1:0] odat
`ifdef PTRANSPOSE_SCATTER_STATS_EN
   ,
   output logic [STAT_W-1:0]    jobs_in,
   output logic [STAT_W-1:0]    jobs_out,
   output logic [STAT_W-1:0]    stall_cnt
`endif
);

   localparam int W     = SIMD * BITS;
   localparam int DEPTH = bank_depth(I, J, SIMD);
   localparam int AW    = $clog2(DEPTH);
   localparam int SW    = $clog2(SIMD);
   localparam int IW    = $clog2(I);
   localparam int JW    = $clog2(J);

   localparam logic [IW-1:0] WI_LAST = IW'(I - SIMD);
   localparam logic [JW-1:0] WJ_LAST = JW'(J - 1);
   localparam logic [IW-1:0] RI_LAST = IW'(I - 1);
   localparam logic [JW-1:0] RJ_LAST = JW'(J - SIMD);

   if ((I % SIMD) != 0 || (J % SIMD) != 0 || SIMD < 2 ||
       (SIMD & (SIMD - 1)) != 0) begin : g_bad_geom
      $error("ptranspose_scatter: I, J must be multiples of pow2 SIMD>=2");
   end

   // page state
   logic [1:0]      r_full;
   logic            r_wpg;
   logic            r_rpg;
   logic [1:0]      w_set;
   logic [1:0]      w_clr;

   // write / read position counters
   logic [IW-1:0]   r_wi;
   logic [JW-1:0]   r_wj;
   logic [IW-1:0]   r_ri;
   logic [JW-1:0]   r_rj;

   // bank output stage and output skid pair
   logic            r_s1_vld;
   logic [SW-1:0]   r_s1_rot;
   logic            r_ovld;
   logic [W-1:0]    r_odat;
   logic            r_skid_vld;
   logic [W-1:0]    r_skid_dat;

   logic            w_wr;
   logic            w_wlast;
   logic            w_iss;
   logic            w_rlast;
   logic            w_s2_rdy;
   logic            w_adv;
   logic [SW-1:0]   w_lane  [SIMD];
   logic [BITS-1:0] w_wdat  [SIMD];
   logic [AW-1:0]   w_waddr [SIMD];
   logic [AW-1:0]   w_raddr;
   logic [BITS-1:0] w_bank_q [SIMD];
   logic [W-1:0]    w_s1_dat;

   // ---------------- write side ----------------
   assign irdy    = !r_full[r_wpg];
   assign w_wr    = ivld && irdy;
   assign w_wlast = w_wr && (r_wj == WJ_LAST) && (r_wi == WI_LAST);

   always_comb begin
      for (int b = 0; b < SIMD; b++) begin
         w_lane[b]  = SW'(lane_of(b, int'(r_wj), SIMD));
         w_wdat[b]  = '0;
         for (int k = 0; k < SIMD; k++) begin
            if (w_lane[b] == SW'(k)) begin
               w_wdat[b] = idat[k*BITS +: BITS];
            end
         end
         w_waddr[b] = AW'(bank_addr(r_wpg,
                                    int'(r_wi) + int'(w_lane[b]),
                                    int'(r_wj), I, J, SIMD));
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wi  <= '0;
         r_wj  <= '0;
         r_wpg <= 1'b0;
      end else if (w_wr) begin
         if (r_wi == WI_LAST) begin
            r_wi <= '0;
            if (r_wj == WJ_LAST) begin
               r_wj  <= '0;
               r_wpg <= !r_wpg;
            end else begin
               r_wj <= r_wj + JW'(1);
            end
         end else begin
            r_wi <= r_wi + IW'(SIMD);
         end
      end
   end

   // ---------------- page flags ----------------
   // A set and a clear never target the same page in one cycle: a page
   // being written is empty, a page being read is full.
   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (w_wlast) begin
         w_set[r_wpg] = 1'b1;
      end
      if (w_rlast) begin
         w_clr[r_rpg] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_full <= '0;
      end else begin
         r_full <= (r_full | w_set) & ~w_clr;
      end
   end

   // ---------------- read side ----------------
   // Bank registers hold while the stage is stalled, so a read is only
   // issued when the registered word is empty or leaving this cycle.
   assign w_s2_rdy = !r_skid_vld;
   assign w_adv    = r_s1_vld && w_s2_rdy;
   assign w_iss    = r_full[r_rpg] && (!r_s1_vld || w_s2_rdy);
   assign w_rlast  = w_iss && (r_ri == RI_LAST) && (r_rj == RJ_LAST);
   assign w_raddr  = AW'(bank_addr(r_rpg, int'(r_ri), int'(r_rj),
                                   I, J, SIMD));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ri  <= '0;
         r_rj  <= '0;
         r_rpg <= 1'b0;
      end else if (w_iss) begin
         if (r_rj == RJ_LAST) begin
            r_rj <= '0;
            if (r_ri == RI_LAST) begin
               r_ri  <= '0;
               r_rpg <= !r_rpg;
            end else begin
               r_ri <= r_ri + IW'(1);
            end
         end else begin
            r_rj <= r_rj + JW'(SIMD);
         end
      end
   end

   for (genvar b = 0; b < SIMD; b++) begin : g_bank
      ptranspose_scatter_bank #(
         .BITS  (BITS),
         .DEPTH (DEPTH),
         .AW    (AW)
      ) u_bank (
         .clk     (clk),
         .i_we    (w_wr),
         .i_waddr (w_waddr[b]),
         .i_wdata (w_wdat[b]),
         .i_re    (w_iss),
         .i_raddr (w_raddr),
         .o_rdata (w_bank_q[b])
      );
   end

   // Row ri starts in bank ri%SIMD; the amount travels with the read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld <= 1'b0;
         r_s1_rot <= '0;
      end else if (w_iss) begin
         r_s1_vld <= 1'b1;
         r_s1_rot <= r_ri[SW-1:0];
      end else if (w_adv) begin
         r_s1_vld <= 1'b0;
      end
   end

   always_comb begin
      w_s1_dat = '0;
      for (int k = 0; k < SIMD; k++) begin
         for (int b = 0; b < SIMD; b++) begin
            if (SW'(rot_lanes(k, int'(r_s1_rot), SIMD)) == SW'(b)) begin
               w_s1_dat[k*BITS +: BITS] = w_bank_q[b];
            end
         end
      end
   end

   // ---------------- output skid buffer ----------------
   // Upstream ready is registered (!r_skid_vld); a beat accepted while
   // the output is stalled parks in the skid register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovld     <= 1'b0;
         r_odat     <= '0;
         r_skid_vld <= 1'b0;
         r_skid_dat <= '0;
      end else if (!r_ovld || ordy) begin
         if (r_skid_vld) begin
            r_ovld     <= 1'b1;
            r_odat     <= r_skid_dat;
            r_skid_vld <= 1'b0;
         end else if (w_adv) begin
            r_ovld <= 1'b1;
            r_odat <= w_s1_dat;
         end else begin
            r_ovld <= 1'b0;
         end
      end else if (w_adv) begin
         r_skid_vld <= 1'b1;
         r_skid_dat <= w_s1_dat;
      end
   end

   assign ovld = r_ovld;
   assign odat = r_odat;

`ifdef PTRANSPOSE_SCATTER_STATS_EN
   localparam int BPJ = beats_per_job(I, J, SIMD);
   localparam int OCW = $clog2(BPJ);
   localparam logic [OCW-1:0] OC_LAST = OCW'(BPJ - 1);

   logic [STAT_W-1:0] r_jin;
   logic [STAT_W-1:0] r_jout;
   logic [STAT_W-1:0] r_stall;
   logic [OCW-1:0]    r_ocnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_jin   <= '0;
         r_jout  <= '0;
         r_stall <= '0;
         r_ocnt  <= '0;
      end else begin
         if (w_wlast) begin
            r_jin <= r_jin + STAT_W'(1);
         end
         if (ivld && !irdy) begin
            r_stall <= r_stall + STAT_W'(1);
         end
         if (r_ovld && ordy) begin
            if (r_ocnt == OC_LAST) begin
               r_ocnt <= '0;
               r_jout <= r_jout + STAT_W'(1);
            end else begin
               r_ocnt <= r_ocnt + OCW'(1);
            end
         end
      end
   end

   assign jobs_in   = r_jin;
   assign jobs_out  = r_jout;
   assign stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_ptranspose_scatter.sv
// tb_ptranspose_scatter: directed stimulus with a scoreboard queue for
// ptranspose_scatter at I=8, J=8, SIMD=4, BITS=8.
module tb_ptranspose_scatter;

   localparam int BITS = 8;
   localparam int I    = 8;
   localparam int J    = 8;
   localparam int SIMD = 4;
   localparam int W    = SIMD * BITS;

   logic         clk  = 1'b0;
   logic         rst  = 1'b1;
   logic         ivld = 1'b0;
   logic         ordy = 1'b1;
   logic [W-1:0] idat = '0;
   logic         irdy;
   logic         ovld;
   logic [W-1:0] odat;
`ifdef PTRANSPOSE_SCATTER_STATS_EN
   logic [31:0]  jobs_in;
   logic [31:0]  jobs_out;
   logic [31:0]  stall_cnt;
`endif

   int n_vec     = 0;
   int n_err     = 0;
   int cyc       = 0;
   int n_in      = 0;
   int n_out     = 0;
   int n_stall   = 0;
   int jobs_sent = 0;
   int last_out  = 0;
   int gap_pct   = 0;
   bit rnd_on    = 1'b0;

   logic [W-1:0] exp_q [$];
   logic [W-1:0] exp_b;

   ptranspose_scatter #(
      .BITS (BITS),
      .I    (I),
      .J    (J),
      .SIMD (SIMD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .irdy      (irdy),
      .ivld      (ivld),
      .idat      (idat),
      .ordy      (ordy),
      .ovld      (ovld),
      .odat      (odat)
`ifdef PTRANSPOSE_SCATTER_STATS_EN
      ,
      .jobs_in   (jobs_in),
      .jobs_out  (jobs_out),
      .stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(posedge clk) begin
      if (rnd_on) begin
         #1;
         ordy = ($urandom_range(0, 1) == 1);
      end
   end

   // Monitor: compares every output handshake against the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (ivld && irdy) n_in++;
         if (ivld && !irdy) n_stall++;
         if (ovld && ordy) begin
            n_out++;
            n_vec++;
            last_out = cyc;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL beat_unexpected got=%h", odat);
            end else begin
               exp_b = exp_q.pop_front();
               if (odat !== exp_b) begin
                  n_err++;
                  $display("FAIL beat_%0d got=%h exp=%h",
                           n_out, odat, exp_b);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Element (i,j) of job n; job 0 gives i*8+j exactly.
   function automatic logic [BITS-1:0] val(input int n, input int i,
                                           input int j);
      return BITS'(i * J + j + n * 13);
   endfunction

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, want);
      end
   endtask

   task automatic push_exp(input int n);
      logic [W-1:0] e;
      for (int i = 0; i < I; i++) begin
         for (int j0 = 0; j0 < J; j0 += SIMD) begin
            for (int k = 0; k < SIMD; k++) begin
               e[k*BITS +: BITS] = val(n, i, j0 + k);
            end
            exp_q.push_back(e);
         end
      end
   endtask

   // Holds a beat until accepted; hs is the cycle of the handshake.
   task automatic send_beat(input logic [W-1:0] d, output int hs);
      bit ok;
      int w;
      ok   = 1'b0;
      w    = 0;
      hs   = 0;
      idat = d;
      ivld = 1'b1;
      while (!ok) begin
         @(negedge clk);
         ok = irdy && !rst;
         hs = cyc;
         @(posedge clk);
         #1;
         w++;
         if (w > 1000) begin
            $display("FAIL send_timeout irdy=%b", irdy);
            $fatal(1, "send timeout");
         end
      end
   endtask

   task automatic send_job(input int n, output int t0, output int t1);
      logic [W-1:0] d;
      int h;
      t0 = 0;
      t1 = 0;
      push_exp(n);
      jobs_sent++;
      for (int j = 0; j < J; j++) begin
         for (int i0 = 0; i0 < I; i0 += SIMD) begin
            for (int k = 0; k < SIMD; k++) begin
               d[k*BITS +: BITS] = val(n, i0 + k, j);
            end
            if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
               ivld = 1'b0;
               @(posedge clk);
               #1;
            end
            send_beat(d, h);
            if (j == 0 && i0 == 0) t0 = h;
            t1 = h;
         end
      end
      ivld = 1'b0;
   endtask

   task automatic drain(input string nm);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 2000) begin
         @(negedge clk);
         w++;
      end
      chk(nm, exp_q.size(), 0);
   endtask

   initial begin
      int t0, t1, first, seen, b_in, b_out, b_stall, h;
      logic [W-1:0] d;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_irdy", irdy, 1);
      chk("rst_ovld", ovld, 0);
      chk("rst_odat", odat, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_irdy", irdy, 1);

      // single job: values 0..63, first beat 03020100, latency 3
      b_out = n_out;
      send_job(0, t0, t1);
      seen = -1;
      for (int w = 0; w < 10 && seen < 0; w++) begin
         @(negedge clk);
         if (ovld) seen = cyc;
      end
      chk("latency", seen - t1, 3);
      drain("drain_single");
      chk("beats_single", n_out - b_out, 16);

      // four back-to-back jobs at II=1
      @(posedge clk);
      #1;
      b_out   = n_out;
      b_stall = n_stall;
      send_job(1, t0, t1);
      first = t0;
      send_job(2, t0, t1);
      send_job(3, t0, t1);
      send_job(4, t0, t1);
      chk("b2b_in_span", t1 - first, 63);
      chk("b2b_stalls", n_stall - b_stall, 0);
      drain("drain_b2b");
      chk("b2b_beats", n_out - b_out, 64);
      chk("b2b_out_end", last_out - t1, 18);

      // reset in the middle of the second stored job
      @(posedge clk);
      #1;
      ordy = 1'b0;
      send_job(5, t0, t1);
      for (int b = 0; b < 8; b++) begin
         for (int k = 0; k < SIMD; k++) begin
            d[k*BITS +: BITS] = val(6, (b % 2) * SIMD + k, b / 2);
         end
         send_beat(d, h);
      end
      ivld = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_ovld", ovld, 1);
      rst = 1'b1;
      #1;
      chk("rst_async_ovld", ovld, 0);
      exp_q.delete();
      n_stall   = 0;
      jobs_sent = 0;
      @(posedge clk);
      #1;
      rst  = 1'b0;
      ordy = 1'b1;
      chk("rst_rel_irdy", irdy, 1);
      repeat (5) @(negedge clk);
      chk("no_stale_ovld", ovld, 0);
      @(posedge clk);
      #1;
      b_out = n_out;
      send_job(7, t0, t1);
      drain("drain_post_rst");
      chk("post_rst_beats", n_out - b_out, 16);

      // output held off: two pages fill, then input stalls
      @(posedge clk);
      #1;
      ordy  = 1'b0;
      b_in  = n_in;
      b_out = n_out;
      fork
         begin
            send_job(8, t0, t1);
            send_job(9, t0, t1);
            send_job(10, t0, t1);
         end
         begin
            repeat (40) @(negedge clk);
            chk("stall_accepted", n_in - b_in, 32);
            chk("stall_irdy", irdy, 0);
            @(posedge clk);
            #1;
            ordy = 1'b1;
         end
      join
      drain("drain_stall");
      chk("stall_beats", n_out - b_out, 48);

      // random gaps on both sides
      @(posedge clk);
      #1;
      gap_pct = 50;
      rnd_on  = 1'b1;
      b_out   = n_out;
      for (int n = 11; n < 41; n++) begin
         send_job(n, t0, t1);
      end
      gap_pct = 0;
      @(negedge clk);
      rnd_on = 1'b0;
      @(posedge clk);
      #1;
      ordy = 1'b1;
      drain("drain_rand");
      chk("rand_beats", n_out - b_out, 480);

`ifdef PTRANSPOSE_SCATTER_STATS_EN
      repeat (2) @(negedge clk);
      chk("jobs_in", jobs_in, jobs_sent);
      chk("jobs_out", jobs_out, jobs_sent);
      chk("stall_cnt", stall_cnt, n_stall);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
